// File: rtl/noise_sampler_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// baby_kyber_pkg : shared ring parameters, coefficient type and sampler states
// Revision 1.0
// ----------------------------------------------------------------------------
package baby_kyber_pkg;

  localparam int Q = 17;
  localparam int K = 2;
  localparam int N = 4;

  typedef logic signed [31:0] coef_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_HOLD   = 2'd2
  } sampler_state_e;

endpackage
`default_nettype wire

// File: rtl/noise_sampler_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// noise_sampler_if : request / random-byte / result bundle of the noise sampler
// Revision 1.0
// ----------------------------------------------------------------------------
interface noise_sampler_if #(
  parameter int K = baby_kyber_pkg::K,
  parameter int N = baby_kyber_pkg::N
);
  import baby_kyber_pkg::*;

  logic                    start;
  logic                    rnd_valid;
  logic [7:0]              rnd_data;
  logic                    rnd_ready;
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready;
  coef_t [K-1:0][N-1:0]    secret_key;
  coef_t [K-1:0][N-1:0]    e;

  modport master (
    output start, rnd_valid, rnd_data, out_ready,
    input  rnd_ready, busy, out_valid, secret_key, e
  );

  modport slave (
    input  start, rnd_valid, rnd_data, out_ready,
    output rnd_ready, busy, out_valid, secret_key, e
  );

endinterface
`default_nettype wire

// File: rtl/noise_sampler_cbd.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cbd_nibble : centered-binomial (eta=2) map of one nibble to a coefficient
// Option NOISE_SAMPLER_MOD_Q_EN stores negatives as value+Q. Revision 1.0
// ----------------------------------------------------------------------------
module cbd_nibble
  import baby_kyber_pkg::*;
#(
  parameter int Q = baby_kyber_pkg::Q
) (
  input  logic [3:0] nibble_i,
  output coef_t      coef_o
);

  logic [1:0] pos;
  logic [1:0] neg;
  coef_t      raw;

  assign pos = {1'b0, nibble_i[0]} + {1'b0, nibble_i[1]};
  assign neg = {1'b0, nibble_i[2]} + {1'b0, nibble_i[3]};
  assign raw = coef_t'({30'd0, pos}) - coef_t'({30'd0, neg});

`ifdef NOISE_SAMPLER_MOD_Q_EN
  assign coef_o = raw[31] ? raw + coef_t'(Q) : raw;
`else
  assign coef_o = raw;
`endif

  // A modulus of 2 or less cannot hold the -2..+2 range after reduction.
  if (Q <= 2) begin : g_q_check
    $error("cbd_nibble: Q must be greater than 2");
  end

endmodule
`default_nettype wire

// File: rtl/noise_sampler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// noise_sampler : fills secret_key then e from random bytes, two coefs per byte
// Option NOISE_SAMPLER_MOD_Q_EN (coefficients reduced into 0..Q-1). Revision 1.0
// ----------------------------------------------------------------------------
module noise_sampler
  import baby_kyber_pkg::*;
#(
  parameter int Q = baby_kyber_pkg::Q,
  parameter int K = baby_kyber_pkg::K,
  parameter int N = baby_kyber_pkg::N
) (
  input  logic            clk,
  input  logic            rst,
  noise_sampler_if.slave  bus
);

  localparam int NBYTES = K * N;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  sampler_state_e          state_q;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           cnt_d;
  logic                    rnd_ready_q;
  logic                    busy_q;
  logic                    out_valid_q;
  coef_t [K-1:0][N-1:0]    sk_q;
  coef_t [K-1:0][N-1:0]    e_q;

  coef_t                   coef_lo;
  coef_t                   coef_hi;
  logic                    accept;
  logic                    last_byte;

  cbd_nibble #(.Q(Q)) u_cbd_lo (.nibble_i(bus.rnd_data[3:0]), .coef_o(coef_lo));
  cbd_nibble #(.Q(Q)) u_cbd_hi (.nibble_i(bus.rnd_data[7:4]), .coef_o(coef_hi));

  // rnd_ready_q is high exactly in SAMPLE, so it doubles as the state qualifier.
  assign accept    = rnd_ready_q & bus.rnd_valid;
  assign last_byte = (cnt_q == CW'(NBYTES - 1));
  assign cnt_d     = last_byte ? '0 : cnt_q + 1'b1;

  if ((N % 2) != 0) begin : g_n_check
    $error("noise_sampler: N must be even");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rnd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sk_q        <= '0;
      e_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q     <= S_SAMPLE;
            cnt_q       <= '0;
            rnd_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_SAMPLE: begin
          if (accept) begin
            cnt_q <= cnt_d;
            if (last_byte) begin
              state_q     <= S_HOLD;
              rnd_ready_q <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rnd_ready_q <= 1'b0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase

      // Coefficient c of the flat (secret_key, e) sequence comes from byte c/2.
      if (accept) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < N; c++) begin
            if (int'(cnt_q) == (r * N + c) / 2)
              sk_q[r][c] <= (c % 2 == 1) ? coef_hi : coef_lo;
            if (int'(cnt_q) == (K * N + r * N + c) / 2)
              e_q[r][c] <= (c % 2 == 1) ? coef_hi : coef_lo;
          end
        end
      end
    end
  end

  assign bus.rnd_ready  = rnd_ready_q;
  assign bus.busy       = busy_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.secret_key = sk_q;
  assign bus.e          = e_q;

endmodule
`default_nettype wire

// File: doc/noise_sampler.md
NOISE_SAMPLER -- requirements
Module: noise_sampler

Interface
REQ-001 Parameter Q, default 17: coefficient modulus.
REQ-002 Parameter K, default 2: polynomial rows per vector.
REQ-003 Parameter N, default 4: coefficients per polynomial.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a sampling run.
REQ-007 rnd_valid  input  1  random byte available on rnd_data.
REQ-008 rnd_data  input  8  random byte.
REQ-009 rnd_ready  output  1  sampler accepts rnd_data this cycle.
REQ-010 busy  output  1  high in SAMPLE and HOLD.
REQ-011 out_valid  output  1  secret_key and e complete and stable.
REQ-012 out_ready  input  1  downstream key-generation stage consumes the result.
REQ-013 secret_key  output  signed 32 x [K][N]  sampled secret vector.
REQ-014 e  output  signed 32 x [K][N]  sampled error vector.

Function
REQ-015 The FSM SHALL have states IDLE, SAMPLE and HOLD.
REQ-016 IDLE->SAMPLE SHALL occur on start=1; the byte counter SHALL clear to 0.
REQ-017 rnd_ready SHALL be 1 exactly when state is SAMPLE; a byte is accepted when rnd_valid and rnd_ready are both 1.
REQ-018 Each accepted byte SHALL yield two coefficients: low nibble to even index, high nibble to odd index.
REQ-019 Nibble mapping (centered binomial, eta=2): coef = (bit0+bit1) - (bit2+bit3), range -2..+2.
REQ-020 Byte k (0..7) SHALL write: k=0,1 -> secret_key[0]; k=2,3 -> secret_key[1]; k=4,5 -> e[0]; k=6,7 -> e[1]; within a row, byte 2m writes indices 0,1 and byte 2m+1 writes indices 2,3.
REQ-021 Coefficients SHALL be sign-extended to 32 bits and written to registered outputs.
REQ-022 After the 8th accepted byte, the FSM SHALL enter HOLD and assert out_valid on the next cycle edge; the counter SHALL wrap to 0.
REQ-023 Minimum latency: start in cycle 0, bytes accepted cycles 1..8, out_valid=1 from cycle 9.
REQ-024 rnd_valid gaps SHALL stall sampling with no change to the counter or outputs.
REQ-025 In HOLD, outputs SHALL remain stable until out_ready=1; HOLD->IDLE on out_ready, out_valid dropping the following cycle.
REQ-026 start SHALL be ignored in SAMPLE and HOLD.
REQ-027 Outputs SHALL retain the last result in IDLE and be overwritten only by a new run.

Reset
REQ-028 While rst=1, the FSM SHALL be IDLE, the counter 0, and rnd_ready, busy, out_valid and all secret_key/e coefficients 0.
REQ-029 rst asserted mid-SAMPLE or mid-HOLD SHALL abort the run immediately and asynchronously; no partial result is retained.

Configuration
REQ-030 Macro NOISE_SAMPLER_MOD_Q_EN: when defined, each coefficient SHALL be stored reduced into 0..Q-1 (negative values plus Q, e.g. -1 -> 16, -2 -> 15).
REQ-031 Without NOISE_SAMPLER_MOD_Q_EN, coefficients SHALL be stored as signed values -2..+2.

Structure
REQ-032 Package baby_kyber_pkg SHALL hold Q, K, N, the 32-bit signed coef_t typedef and the sampler state enum.
REQ-033 The nibble-to-coefficient mapping SHALL be a combinational sub-module cbd_nibble, instantiated twice.

Verification
REQ-034 Eight bytes of 0x00 -> all 16 coefficients 0, out_valid at cycle 9.
REQ-035 Eight bytes of 0x33 -> all coefficients +2; eight bytes of 0xCC -> all -2 (15 with NOISE_SAMPLER_MOD_Q_EN).
REQ-036 Bytes 0x01,0x04,0x03,0x0C,0x05,0x0F,0x30,0xC0 -> secret_key[0]={1,0,-1,0}, secret_key[1]={2,0,-2,0}, e[0]={0,0,0,0}, e[1]={0,2,0,-2}.
REQ-037 Random rnd_valid gaps of 0-5 cycles -> same result as gap-free run; out_ready held low 20 cycles -> outputs unchanged, out_valid held.
REQ-038 rst pulsed after 4th byte -> all outputs 0 and state IDLE; a subsequent full run yields the correct fresh result.
